// File: rtl/q_table_updater.sv
// Q-learning table writer: owns the 64x4 Q8.8 table, serves the policy read port and applies one
// shift-based update per accepted experience tuple. Define Q_SATURATE_EN to clamp Q_new instead of wrapping.
module q_table_updater #(
    parameter int          ALPHA_SHIFT = 2,
    parameter int          GAMMA_SHIFT = 3,
    parameter logic [15:0] INIT_Q      = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  current_state,
    output logic [63:0] q_values,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [5:0]  st,
    input  logic [3:0]  at,
    input  logic [5:0]  st_next,
    input  logic [15:0] reward,
    input  logic        terminal,
    output logic        upd_done,
    output logic [15:0] upd_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAXQ  = 2'd1,
        ST_CALC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic [15:0] q_table_r [0:63][0:3];

    logic [5:0]         st_r;
    logic [1:0]         at_r;
    logic [5:0]         st_next_r;
    logic signed [15:0] reward_r;
    logic               terminal_r;
    logic signed [15:0] maxq_r;
    logic [15:0]        qnew_r;

    logic               ready_r;
    logic               done_r;
    logic [15:0]        count_r;

    logic               accept_s;
    logic               ready_s;
    logic               unused_at_s;

    logic signed [15:0] row_s [0:3];
    logic signed [15:0] m01_s;
    logic signed [15:0] m23_s;
    logic signed [15:0] maxq_s;

    logic signed [15:0] q_cur_s;
    logic signed [17:0] reward_x_s;
    logic signed [17:0] maxq_x_s;
    logic signed [17:0] q_x_s;
    logic signed [17:0] target_s;
    logic signed [17:0] delta_s;
    logic signed [17:0] sum_s;
    logic [15:0]        qnew_s;

    // Reduce the 18-bit update result to a 16-bit table entry
    function automatic logic [15:0] reduce_q(input logic signed [17:0] v);
`ifdef Q_SATURATE_EN
        if (v > 18'sd32767) begin
            reduce_q = 16'h7FFF;
        end else if (v < -18'sd32768) begin
            reduce_q = 16'h8000;
        end else begin
            reduce_q = 16'(v);
        end
`else
        reduce_q = 16'(v);
`endif
    endfunction

    assign accept_s    = upd_valid && ready_r;
    assign unused_at_s = ^at[3:2];

    assign q_values  = {q_table_r[current_state][3], q_table_r[current_state][2],
                        q_table_r[current_state][1], q_table_r[current_state][0]};
    assign upd_ready = ready_r;
    assign upd_done  = done_r;
    assign upd_count = count_r;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Fixed four-step sequence; ready is registered from the next state
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_MAXQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MAXQ:  next_state_s = ST_CALC;
            ST_CALC:  next_state_s = ST_WRITE;
            ST_WRITE: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
        ready_s = (next_state_s == ST_IDLE);
    end

    // Signed max over row st_next of the unmodified table; a terminal transition bootstraps from zero
    always_comb begin
        for (int a = 0; a < 4; a++) begin
            row_s[a] = q_table_r[st_next_r][a];
        end
        m01_s = (row_s[1] > row_s[0]) ? row_s[1] : row_s[0];
        m23_s = (row_s[3] > row_s[2]) ? row_s[3] : row_s[2];
        if (terminal_r) begin
            maxq_s = 16'sh0000;
        end else begin
            maxq_s = (m23_s > m01_s) ? m23_s : m01_s;
        end
    end

    // Q_new = Q + ((r + maxQ' - maxQ'>>>G) - Q) >>> A, with 2 guard bits
    always_comb begin
        q_cur_s    = q_table_r[st_r][at_r];
        reward_x_s = {{2{reward_r[15]}}, reward_r};
        maxq_x_s   = {{2{maxq_r[15]}}, maxq_r};
        q_x_s      = {{2{q_cur_s[15]}}, q_cur_s};
        target_s   = reward_x_s + maxq_x_s - (maxq_x_s >>> GAMMA_SHIFT);
        delta_s    = target_s - q_x_s;
        sum_s      = q_x_s + (delta_s >>> ALPHA_SHIFT);
        qnew_s     = reduce_q(sum_s);
    end

    // Tuple capture at accept, then maxQ' and Q_new pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_r       <= 6'd0;
            at_r       <= 2'd0;
            st_next_r  <= 6'd0;
            reward_r   <= 16'sh0000;
            terminal_r <= 1'b0;
            maxq_r     <= 16'sh0000;
            qnew_r     <= 16'h0000;
        end else begin
            if (state_r == ST_IDLE && accept_s) begin
                st_r       <= st;
                at_r       <= at[1:0];
                st_next_r  <= st_next;
                reward_r   <= reward;
                terminal_r <= terminal;
            end
            if (state_r == ST_MAXQ) begin
                maxq_r <= maxq_s;
            end
            if (state_r == ST_CALC) begin
                qnew_r <= qnew_s;
            end
        end
    end

    // Q table storage; reset reinitialises every entry so an aborted update leaves no trace
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 64; r++) begin
                for (int a = 0; a < 4; a++) begin
                    q_table_r[r][a] <= INIT_Q;
                end
            end
        end else if (state_r == ST_WRITE) begin
            q_table_r[st_r][at_r] <= qnew_r;
        end
    end

    // Handshake and completion status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            count_r <= 16'd0;
        end else begin
            ready_r <= ready_s;
            done_r  <= (state_r == ST_WRITE);
            if (state_r == ST_WRITE) begin
                count_r <= count_r + 16'd1;
            end
        end
    end

endmodule

// File: doc/q_table_updater.md
# q_table_updater

- Write-side counterpart of the policy generator.
- Owns the 64-state × 4-action Q table and serves the generator's 64-bit `q_values` read.
- Accepts one experience tuple (st, at, st_next, reward) per handshake and applies a shift-based Q-learning update to entry Q(st, at) in a fixed 4-cycle sequence.
- Sits between the environment/reward logic and the policy generator, closing the learning loop.

## Interface
Parameters:
- `ALPHA_SHIFT`, default 2: learning rate α = 2^-ALPHA_SHIFT. Legal range 0–15.
- `GAMMA_SHIFT`, default 3: discount γ = 1 − 2^-GAMMA_SHIFT. Legal range 1–15.
- `INIT_Q`, default 16'h0000: reset value of every table entry.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `current_state` in 6: read-port row select.
- `q_values` out 64: row `current_state`, combinational. Action a occupies bits [16a+15:16a].
- `upd_valid` in 1: experience tuple valid.
- `upd_ready` out 1: high only in IDLE.
- `st` in 6: state the action was taken in.
- `at` in 4: action index. Only bits [1:0] are used; bits [3:2] are ignored.
- `st_next` in 6: resulting state.
- `reward` in 16: signed Q8.8 reward.
- `terminal` in 1: st_next is terminal, so the bootstrap term is 0.
- `upd_done` out 1: one-cycle pulse after the table write.
- `upd_count` out 16: number of completed updates, wraps at 2^16.

## Operation
- Table entries are signed 16-bit Q8.8 values, 64 rows × 4 actions.
- On reset:
  - All entries are set to INIT_Q.
  - FSM goes to IDLE.
  - `upd_ready`=1, `upd_done`=0, `upd_count`=0.
- FSM states and transitions:
  - IDLE: on `upd_valid && upd_ready`, capture st, at[1:0], st_next, reward and terminal, then go to MAXQ.
  - MAXQ: register maxQ' = max of the 4 entries of row st_next, signed. Ties resolve to the lowest action index; only the value is used. If terminal=1, maxQ' = 0. Go to CALC.
  - CALC: read Q = Q(st, at) and compute in 18-bit signed arithmetic:
    - target = reward + maxQ' − (maxQ' >>> GAMMA_SHIFT)
    - delta = target − Q
    - Q_new = Q + (delta >>> ALPHA_SHIFT), using arithmetic shifts.
    - Register Q_new reduced to 16 bits (see Configuration). Go to WRITE.
  - WRITE: at the next edge, write Q_new into Q(st, at), pulse `upd_done`, increment `upd_count` and return to IDLE.
- st == st_next is legal. MAXQ uses the pre-update row.
- `q_values` always reflects the table's current contents. A row being written changes in the cycle after the WRITE edge.
- Inputs are sampled only at the accept edge. Changes to them during MAXQ, CALC or WRITE have no effect.
- Reset asserted mid-sequence aborts the update: no write occurs, and the whole table is reinitialised to INIT_Q.

## Timing
- Accept edge E0: state becomes MAXQ.
- E1: state becomes CALC.
- E2: state becomes WRITE.
- E3: entry written, state becomes IDLE, `upd_done`=1 for the cycle following E3, `upd_count` incremented.
- `upd_ready` is low from E0 through E3 and high again in the cycle after E3.
- A tuple held valid in that cycle is accepted at E4.
- Maximum throughput is one update per 4 cycles.
- `q_values` has zero latency from `current_state`.

## Configuration
- `Q_SATURATE_EN`
  - Defined: Q_new is clamped to [−32768, 32767] (16'h8000 to 16'h7FFF) before the write.
  - Undefined: Q_new is truncated to its low 16 bits, so values wrap two's-complement.

## Test plan
- After reset with INIT_Q=0, update (st=5, at=2, st_next=6, reward=16'h0100, terminal=0) → with current_state=5, `q_values`[47:32]=16'h0040 and all other fields 0. `upd_done` pulses 4 cycles after accept and `upd_count`=1.
- Bootstrapped update, default shifts:
  - Update (st=6, at=1, terminal=1, reward=16'h0800) → Q(6,1)=16'h0200.
  - Then update (st=5, at=2, st_next=6, reward=0, terminal=0) → Q(5,2)=16'h00A0.
  - Repeat the second update with terminal=1 instead → Q(5,2)=16'h0030 instead.
- Saturation, with ALPHA_SHIFT=0:
  - Update (st=6, at=0, terminal=1, reward=16'h7000) → Q(6,0)=16'h7000.
  - Then update (st=5, at=0, st_next=6, reward=16'h7FFF, terminal=0) → Q(5,0)=16'h7FFF with `Q_SATURATE_EN` defined, 16'hE1FF without.
- Hold `upd_valid`=1 continuously for 3 tuples → accepts occur 4 cycles apart, `upd_ready` is low in the 3 cycles between accepts, and `upd_count`=3.
- Assert `rst` for one cycle while in CALC after 2 prior completed updates → no write occurs, every entry reads INIT_Q, `upd_ready`=1 and `upd_count`=0.
